fifo_wr_sched: RTL and testbench

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

---
 rtl/fifo_wr_sched_if.sv | 16 +
 rtl/fifo_wr_sched.sv | 99 +++++++++
 tb/tb_fifo_wr_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_sched_if.sv
// Requester-side and memory-side write bus of the FIFO write scheduler.
interface fifo_wr_sched_if #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_SIZE    = 8,
    parameter int NUM_REQ      = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] wdata_in;
    logic [NUM_REQ-1:0]           gnt;
    logic                         wen;
    logic [ADDRESS_SIZE-1:0]      waddr;
    logic [DATA_SIZE-1:0]         wdata;

    modport master (output req, wdata_in, input gnt, wen, waddr, wdata);
    modport slave  (input req, wdata_in, output gnt, wen, waddr, wdata);
endinterface

// File: rtl/fifo_wr_sched.sv
// Round-robin multi-requester write side of an async FIFO: arbitration, binary/Gray
// write pointer and full flag. Define FIFO_WR_AFULL_EN to add the wafull output.
module fifo_wr_sched #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_SIZE    = 8,
    parameter int NUM_REQ      = 4,
    parameter int AFULL_GAP    = 2
) (
    input  logic                  wclk,
    input  logic                  wrst,
    fifo_wr_sched_if.slave        bus,
    input  logic [ADDRESS_SIZE:0] wq2_read_ptr,
    output logic [ADDRESS_SIZE:0] wptr,
`ifdef FIFO_WR_AFULL_EN
    output logic                  wafull,
`endif
    output logic                  wfull
);
    localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = ADDRESS_SIZE + 1;

    logic [LGW-1:0] last_q, last_d;
    logic [PW-1:0]  wbin_q, wbin_d, wgray_d, wptr_q;
    logic           wfull_q, wfull_d;
    logic [NUM_REQ-1:0] gnt_c;
    logic [LGW-1:0] gidx;
    logic           found;
    int             idx;

    // Search starts one past the last winner; full or reset blocks every grant.
    always_comb begin
        gnt_c  = '0;
        gidx   = '0;
        found  = 1'b0;
        idx    = 0;
        last_d = last_q;
        if (wrst && !wfull_q) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_q) + k) % NUM_REQ;
                if (!found && bus.req[idx]) begin
                    found      = 1'b1;
                    gnt_c[idx] = 1'b1;
                    gidx       = LGW'(idx);
                end
            end
        end
        if (found) last_d = gidx;
    end

    assign bus.gnt   = gnt_c;
    assign bus.wen   = found;
    assign bus.waddr = wbin_q[ADDRESS_SIZE-1:0];
    assign bus.wdata = found ? bus.wdata_in[gidx*DATA_SIZE +: DATA_SIZE] : '0;

    assign wbin_d  = wbin_q + PW'(found);
    assign wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the writer is a whole lap ahead: Gray pointers differ only in the two MSBs.
    assign wfull_d = (wgray_d == {~wq2_read_ptr[ADDRESS_SIZE:ADDRESS_SIZE-1],
                                  wq2_read_ptr[ADDRESS_SIZE-2:0]});

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            last_q  <= LGW'(NUM_REQ - 1);
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
            last_q  <= last_d;
        end
    end

    assign wptr  = wptr_q;
    assign wfull = wfull_q;

`ifdef FIFO_WR_AFULL_EN
    localparam logic [PW-1:0] AF_TH = PW'((2 ** ADDRESS_SIZE) - AFULL_GAP);

    logic [PW-1:0] rbin, fill_d;
    logic          wafull_q, wafull_d;

    // Binary bit i is the XOR of all Gray bits at or above i.
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign rbin[i] = ^(wq2_read_ptr >> i);
    end

    assign fill_d   = wbin_d - rbin;
    assign wafull_d = (fill_d >= AF_TH);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) wafull_q <= 1'b0;
        else       wafull_q <= wafull_d;
    end

    assign wafull = wafull_q;
`endif
endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed check of fifo_wr_sched: reset, round-robin order, fill to full, read release, wrap.
module tb_fifo_wr_sched;
    localparam int AS = 4;
    localparam int DS = 8;
    localparam int NR = 4;

    logic          wclk;
    logic          wrst;
    logic [AS:0]   wq2_read_ptr;
    logic [AS:0]   wptr;
    logic          wfull;
`ifdef FIFO_WR_AFULL_EN
    logic          wafull;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_sched_if #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .NUM_REQ(NR)) bus ();

    fifo_wr_sched #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .NUM_REQ(NR), .AFULL_GAP(2)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .bus         (bus.slave),
        .wq2_read_ptr(wq2_read_ptr),
        .wptr        (wptr),
`ifdef FIFO_WR_AFULL_EN
        .wafull      (wafull),
`endif
        .wfull       (wfull)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [AS:0] gray(input logic [AS:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [NR-1:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DS-1:0] exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        wrst         = 1'b0;
        bus.req      = 4'b1111;
        bus.wdata_in = {8'h44, 8'h33, 8'h22, 8'h11};
        wq2_read_ptr = '0;
        #3;
        check("rst_gnt",   32'(bus.gnt),   32'h0);
        check("rst_wen",   32'(bus.wen),   32'h0);
        check("rst_wptr",  32'(wptr),      32'h0);
        check("rst_wfull", 32'(wfull),     32'h0);
        check("rst_waddr", 32'(bus.waddr), 32'h0);
        check("rst_wdata", 32'(bus.wdata), 32'h0);
        tick();
        check("rst_hold_gnt", 32'(bus.gnt), 32'h0);
        wrst = 1'b1;
        #1;

        // Round-robin over four constant requesters starting at requester 0
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_gnt%0d", i),   32'(bus.gnt),   32'(exp_gnt[i]));
            check($sformatf("rr_waddr%0d", i), 32'(bus.waddr), 32'(i));
            check($sformatf("rr_wdata%0d", i), 32'(bus.wdata), 32'(exp_dat[i]));
            tick();
            check($sformatf("rr_wptr%0d", i),  32'(wptr),      32'(gray(5'(i + 1))));
        end

        // Reset mid-burst clears immediately
        wrst = 1'b0;
        #1;
        check("mid_rst_wptr",  32'(wptr),      32'h0);
        check("mid_rst_gnt",   32'(bus.gnt),   32'h0);
        check("mid_rst_wen",   32'(bus.wen),   32'h0);
        check("mid_rst_waddr", 32'(bus.waddr), 32'h0);
        check("mid_rst_wdata", 32'(bus.wdata), 32'h0);
        tick();
        wrst    = 1'b1;
        bus.req = 4'b0100;
        #1;

        // Single requester fills all 16 slots
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_gnt%0d", i),   32'(bus.gnt),   32'h4);
            check($sformatf("fill_waddr%0d", i), 32'(bus.waddr), 32'(i));
            check($sformatf("fill_wdata%0d", i), 32'(bus.wdata), 32'h33);
            if (i < 15) check($sformatf("fill_nfull%0d", i), 32'(wfull), 32'h0);
            tick();
        end
        check("full_wfull", 32'(wfull),     32'h1);
        check("full_wptr",  32'(wptr),      32'h18);
        check("full_gnt",   32'(bus.gnt),   32'h0);
        check("full_wen",   32'(bus.wen),   32'h0);
        check("full_wdata", 32'(bus.wdata), 32'h0);
        tick();
        check("full_hold_wfull", 32'(wfull),   32'h1);
        check("full_hold_gnt",   32'(bus.gnt), 32'h0);

        // One slot released by the reader
        wq2_read_ptr = 5'b00001;
        tick();
        check("rel_wfull", 32'(wfull),     32'h0);
        check("rel_gnt",   32'(bus.gnt),   32'h4);
        check("rel_waddr", 32'(bus.waddr), 32'h0);
        tick();
        check("refull_wfull", 32'(wfull),   32'h1);
        check("refull_wptr",  32'(wptr),    32'h19);
        check("refull_gnt",   32'(bus.gnt), 32'h0);

        // Reader tracking the writer: 32 writes wrap the pointer, never full
        wrst = 1'b0;
        #1;
        wq2_read_ptr = '0;
        bus.req      = 4'b0001;
        tick();
        wrst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("wrap_wen%0d", i),   32'(bus.wen),   32'h1);
            check($sformatf("wrap_waddr%0d", i), 32'(bus.waddr), 32'(i % 16));
            tick();
            check($sformatf("wrap_nfull%0d", i), 32'(wfull), 32'h0);
            wq2_read_ptr = gray(5'(i + 1));
            #1;
        end
        check("wrap_wptr", 32'(wptr), 32'h0);

`ifdef FIFO_WR_AFULL_EN
        wrst = 1'b0;
        #1;
        check("af_rst_wafull", 32'(wafull), 32'h0);
        wq2_read_ptr = '0;
        tick();
        wrst = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) tick();
        check("af13_wafull", 32'(wafull), 32'h0);
        tick();
        check("af14_wafull", 32'(wafull), 32'h1);
        check("af14_wfull",  32'(wfull),  32'h0);
        wrst = 1'b0;
        #1;
        check("af_mid_rst_wafull", 32'(wafull), 32'h0);
        check("af_mid_rst_wptr",   32'(wptr),   32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
